merlin_imem_responder: RTL



---
 rtl/merlin_imem_responder.sv | 93 +++++++++
 1 files changed

// File: rtl/merlin_imem_responder.sv
// merlin_imem_responder: in-order instruction-bus responder in front of a synchronous SRAM.
// Define MERLIN_IMEM_HPL_CHECK_EN to fault fetches below C_MIN_HPL.
module merlin_imem_responder #(
  parameter int RV_XLEN = 32,
  parameter int RV_XLEN_X = 5,
  parameter logic [RV_XLEN-1:0] C_ADDR_BASE = {RV_XLEN{1'b0}},
  parameter int C_MEM_DEPTH_X = 12,
  parameter int C_RSP_FIFO_DEPTH_X = 2,
  parameter logic [1:0] C_MIN_HPL = 2'd0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clk_en_i,
  output logic                     ireqready_o,
  input  logic                     ireqvalid_i,
  input  logic [1:0]               ireqhpl_i,
  input  logic [RV_XLEN-1:0]       ireqaddr_i,
  input  logic                     irspready_i,
  output logic                     irspvalid_o,
  output logic                     irsprerr_o,
  output logic [RV_XLEN-1:0]       irspdata_o,
  output logic                     sram_rd_o,
  output logic [C_MEM_DEPTH_X-1:0] sram_addr_o,
  input  logic [RV_XLEN-1:0]       sram_rdata_i,
  output logic [7:0]               err_cnt_o
);
  localparam int DX = C_RSP_FIFO_DEPTH_X;
  localparam int DEPTH = 1 << DX;
  localparam logic [DX+1:0] L_DEPTH = (DX+2)'(DEPTH);
  logic [RV_XLEN:0]              w_sub;
  logic [RV_XLEN-RV_XLEN_X+2:0]  w_off;
  logic                          w_hpl_err, w_err, w_acc, w_push, w_pop;
  logic [DX+1:0]                 w_used;
  logic                          w_unused_lsb;
  logic                          r_s1_vld, r_s1_err;
  logic [DX:0]                   r_lvl;
  logic [DX-1:0]                 r_wp, r_rp;
  logic [7:0]                    r_err_cnt;
  logic                          r_ferr  [DEPTH];
  logic [RV_XLEN-1:0]            r_fdata [DEPTH];

`ifdef MERLIN_IMEM_HPL_CHECK_EN
  assign w_hpl_err = ireqhpl_i < C_MIN_HPL;
`else
  logic w_unused_hpl;
  assign w_hpl_err = 1'b0;
  assign w_unused_hpl = ^{ireqhpl_i, C_MIN_HPL};
`endif

  // Extra top bit of the subtraction is the borrow for addresses below the window.
  assign w_sub = {1'b0, ireqaddr_i} - {1'b0, C_ADDR_BASE};
  assign w_off = w_sub[RV_XLEN-1:RV_XLEN_X-3];
  assign w_unused_lsb = ^w_sub[RV_XLEN_X-4:0];
  assign w_err = w_sub[RV_XLEN] | ((w_off >> C_MEM_DEPTH_X) != '0) | w_hpl_err;
  assign w_acc = ireqvalid_i & ireqready_o & clk_en_i;
  assign sram_rd_o = w_acc & ~w_err;
  assign sram_addr_o = w_off[C_MEM_DEPTH_X-1:0];

  // Credits cover both the FIFO and the request still waiting on SRAM data.
  assign w_used = {1'b0, r_lvl} + (DX+2)'(r_s1_vld);
  assign ireqready_o = (w_used < L_DEPTH) & ~reset_i;
  assign irspvalid_o = r_lvl != '0;
  assign w_push = clk_en_i & r_s1_vld;
  assign w_pop = clk_en_i & irspvalid_o & irspready_i;
  assign irsprerr_o = irspvalid_o & r_ferr[r_rp];
  assign irspdata_o = irspvalid_o ? r_fdata[r_rp] : '0;
  assign err_cnt_o = r_err_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s1_vld <= 1'b0;
      r_s1_err <= 1'b0;
      r_lvl <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_err_cnt <= '0;
    end else if (clk_en_i) begin
      r_s1_vld <= w_acc;
      r_s1_err <= w_err;
      r_wp <= r_wp + DX'(w_push);
      r_rp <= r_rp + DX'(w_pop);
      r_lvl <= r_lvl + (DX+1)'(w_push) - (DX+1)'(w_pop);
      if (w_pop & irsprerr_o & ~&r_err_cnt) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_ferr[r_wp] <= r_s1_err;
      r_fdata[r_wp] <= r_s1_err ? '0 : sram_rdata_i;
    end
  end
endmodule
